// File: rtl/pack_fifo.sv
// Element FIFO that accepts either one element or a packed word of PACK elements per push,
// and pops one element per cycle with first-word-fall-through read data.
module pack_fifo #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned PACK   = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifo_reset_i,
  input  logic                       push_en,
  input  logic                       push_mod,
  input  logic [ELEM_W*PACK-1:0]     push_data,
  input  logic                       pop_en,
  output logic [ELEM_W-1:0]          pop_data,
  output logic                       full,
  output logic                       word_full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [ELEM_W-1:0] mem_q [DEPTH];
  logic [ELEM_W-1:0] mem_d [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic push_one, push_pack, pop_ok;

  // Status is taken from the registered count only; a same-cycle pop gives no push credit.
  assign full      = (count_q == CW'(DEPTH));
  assign word_full = ((CW'(DEPTH) - count_q) < CW'(PACK));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;
  assign pop_data  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    push_one  = push_en & ~push_mod & ~full;
    push_pack = push_en & push_mod & ~word_full;
    pop_ok    = pop_en & ~empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (fifo_reset_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_en && !(push_one || push_pack)) begin
        ovf_d = 1'b1;
      end
      if (pop_en && empty) begin
        udf_d = 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_one) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else if (push_pack) begin
        wr_ptr_d = wr_ptr_q + AW'(PACK);
      end
      count_d = count_q + CW'(push_one) + (push_pack ? CW'(PACK) : '0) - CW'(pop_ok);
    end
  end

  // Packed elements land contiguously modulo DEPTH; pointer arithmetic wraps naturally.
  always_comb begin
    mem_d = mem_q;
    if (!fifo_reset_i) begin
      if (push_one) begin
        mem_d[wr_ptr_q] = push_data[ELEM_W-1:0];
      end
      if (push_pack) begin
        for (int unsigned k = 0; k < PACK; k++) begin
          mem_d[wr_ptr_q + AW'(k)] = push_data[k*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

endmodule
